battleship_attack_engine: RTL

- Parametrised successor of the single-board attack logic.
- Owns NUM_BOARDS ship boards of ROWS x COLS cells and resolves one shot at a time through a valid/ready request and a one-cycle response pulse.
- Per-board life tracking counts ship hits only; repeat and out-of-range shots are flagged and change nothing.
- Sits between the game-control FSM (player and PC turns) and the display/scoring logic.

---
 rtl/battleship_pkg.sv | 40 ++++
 rtl/battleship_board_mem.sv | 85 ++++++++
 rtl/battleship_attack_engine.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/battleship_pkg.sv
// Shared types for the battleship attack engine: cell record, FSM states,
// display codes and a width helper.
// No logic of its own; imported by battleship_board_mem and battleship_attack_engine.
package battleship_pkg;

  // Ship IDs are stored at a fixed width so the cell record can live in the
  // package; NUM_SHIPS must therefore stay below 2**MAX_SHIP_W.
  localparam int MAX_SHIP_W = 4;

  typedef struct packed {
    logic [MAX_SHIP_W-1:0] ship_id;  // 0 = open water
    logic                  shot;     // cell has been fired upon
  } cell_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    RESP   = 2'd3
  } attack_state_e;

  localparam logic [1:0] WATER = 2'd0;
  localparam logic [1:0] SHIP  = 2'd1;
  localparam logic [1:0] MISS  = 2'd2;
  localparam logic [1:0] HIT   = 2'd3;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Display code of a cell.
  function automatic logic [1:0] cell_code(input cell_t c);
    logic [1:0] code;
    if (c.shot) code = (c.ship_id != '0) ? HIT : MISS;
    else        code = (c.ship_id != '0) ? SHIP : WATER;
    return code;
  endfunction

endpackage

// File: rtl/battleship_board_mem.sv
// One ship board: ROWS x COLS cells with a load port, a registered read/modify port and a display port.
// Latency: rd_cell valid the cycle after rd_en; shot_en marks the cell captured by that read.
// Backpressure: none; the attack engine serialises load, read and shot accesses.
//
// Ports: clk/rst (async active-low), clear (sync wipe), load_en/load_row/load_col/load_ship/load_done
// (place a ship in an empty cell), rd_en/rd_row/rd_col/rd_cell (registered read),
// shot_en (set shot bit at last read address), disp_row/disp_col/disp_cell (combinational read).
module battleship_board_mem
  import battleship_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         load_en,
  input  logic [clog2w(ROWS)-1:0]      load_row,
  input  logic [clog2w(COLS)-1:0]      load_col,
  input  logic [MAX_SHIP_W-1:0]        load_ship,
  output logic                         load_done,
  input  logic                         rd_en,
  input  logic [clog2w(ROWS)-1:0]      rd_row,
  input  logic [clog2w(COLS)-1:0]      rd_col,
  output cell_t                        rd_cell,
  input  logic                         shot_en,
  input  logic [clog2w(ROWS)-1:0]      disp_row,
  input  logic [clog2w(COLS)-1:0]      disp_col,
  output cell_t                        disp_cell
);

  localparam int ROW_W = clog2w(ROWS);
  localparam int COL_W = clog2w(COLS);
  localparam int DEPTH = ROWS * COLS;
  localparam int IDX_W = clog2w(DEPTH);

  cell_t             cells [DEPTH];
  logic [IDX_W-1:0]  rd_idx_q;

  function automatic logic in_range(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return (int'(r) < ROWS) && (int'(c) < COLS);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return IDX_W'(int'(r) * COLS + int'(c));
  endfunction

  // A load lands only on in-range water; the engine counts life from load_done.
  always_comb begin
    load_done = 1'b0;
    if (load_en && in_range(load_row, load_col))
      load_done = (cells[to_idx(load_row, load_col)].ship_id == '0);
  end

  always_comb begin
    disp_cell = '0;
    if (in_range(disp_row, disp_col))
      disp_cell = cells[to_idx(disp_row, disp_col)];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
      rd_cell  <= '0;
      rd_idx_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
      rd_cell  <= '0;
      rd_idx_q <= '0;
    end else begin
      if (load_done) begin
        cells[to_idx(load_row, load_col)] <= '{ship_id: load_ship, shot: 1'b0};
      end
      if (rd_en) begin
        rd_idx_q <= to_idx(rd_row, rd_col);
        rd_cell  <= cells[to_idx(rd_row, rd_col)];
      end
      // The modify half of the port reuses the address captured by the read.
      if (shot_en) begin
        cells[rd_idx_q].shot <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/battleship_attack_engine.sv
// Resolves one shot at a time against NUM_BOARDS ship boards and tracks per-board life.
// Latency: request accepted on edge N -> resp_valid high for one cycle during cycle N+3.
// Backpressure: req_ready low while a shot is in flight (READ/UPDATE/RESP) and when clear/load win in IDLE.
//
// Ports: clk, rst (async active-low), clear, load_* (board setup), req_* (attack request),
// resp_* (one-cycle result strobe with held fields), life, game_over, disp_* (combinational view).
// Optional: define SHIP_SUNK_EN to add per-ship remaining-cell counters driving resp_sunk.
module battleship_attack_engine
  import battleship_pkg::*;
#(
  parameter int ROWS       = 5,
  parameter int COLS       = 5,
  parameter int NUM_BOARDS = 2,
  parameter int NUM_SHIPS  = 3,
  parameter int LIFE_W     = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               load_we,
  input  logic [clog2w(NUM_BOARDS)-1:0]      load_board,
  input  logic [clog2w(ROWS)-1:0]            load_row,
  input  logic [clog2w(COLS)-1:0]            load_col,
  input  logic [clog2w(NUM_SHIPS+1)-1:0]     load_ship,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [clog2w(NUM_BOARDS)-1:0]      req_target,
  input  logic [clog2w(ROWS):0]              req_row,
  input  logic [clog2w(COLS):0]              req_col,
  output logic                               resp_valid,
  output logic                               resp_hit,
  output logic                               resp_repeat,
  output logic                               resp_invalid,
  output logic [clog2w(NUM_SHIPS+1)-1:0]     resp_ship,
  output logic                               resp_sunk,
  output logic [NUM_BOARDS*LIFE_W-1:0]       life,
  output logic [NUM_BOARDS-1:0]              game_over,
  input  logic [clog2w(NUM_BOARDS)-1:0]      disp_board,
  input  logic [clog2w(ROWS)-1:0]            disp_row,
  input  logic [clog2w(COLS)-1:0]            disp_col,
  output logic [1:0]                         disp_cell
);

  localparam int BRD_W  = clog2w(NUM_BOARDS);
  localparam int ROW_W  = clog2w(ROWS);
  localparam int COL_W  = clog2w(COLS);
  localparam int SHIP_W = clog2w(NUM_SHIPS + 1);

  attack_state_e state, state_nxt;

  logic [BRD_W-1:0]  tgt_q;
  logic [ROW_W:0]    row_q;
  logic [COL_W:0]    col_q;
  logic              inv_q;

  logic [LIFE_W-1:0] life_q [NUM_BOARDS];
  logic [NUM_BOARDS-1:0] loaded_q;

  logic clear_en, load_go, accept, rd_go, upd_en, range_ok;
  logic hit_now, sunk_now;
  cell_t cur_cell;

  logic [NUM_BOARDS-1:0] load_en, load_done, rd_en, shot_en;
  cell_t rd_cell  [NUM_BOARDS];
  cell_t mem_disp [NUM_BOARDS];

  // Setup traffic is only honoured while idle; clear outranks load, load outranks a request.
  assign clear_en = (state == IDLE) && clear;
  assign load_go  = (state == IDLE) && !clear && load_we &&
                    (load_ship != '0) && (int'(load_ship) <= NUM_SHIPS);
  assign accept   = req_valid && req_ready;

  assign range_ok = (int'(tgt_q) < NUM_BOARDS) && (int'(row_q) < ROWS) && (int'(col_q) < COLS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // An out-of-range shot still passes through UPDATE (with no write) so every
  // response lands at the same fixed latency.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rd_go     = 1'b0;
    upd_en    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !clear && !load_we;
        if (req_valid && !clear && !load_we) state_nxt = READ;
      end
      READ: begin
        rd_go     = range_ok;
        state_nxt = UPDATE;
      end
      UPDATE: begin
        upd_en    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q <= '0;
      row_q <= '0;
      col_q <= '0;
      inv_q <= 1'b0;
    end else begin
      if (accept) begin
        tgt_q <= req_target;
        row_q <= req_row;
        col_q <= req_col;
      end
      if (state == READ) inv_q <= !range_ok;
    end
  end

  // Cell captured during READ, selected from the targeted board.
  always_comb begin
    cur_cell = '0;
    for (int b = 0; b < NUM_BOARDS; b++)
      if (tgt_q == BRD_W'(b)) cur_cell = rd_cell[b];
  end

  assign hit_now = upd_en && !inv_q && !cur_cell.shot && (cur_cell.ship_id != '0);

  always_comb begin
    load_en = '0;
    rd_en   = '0;
    shot_en = '0;
    for (int b = 0; b < NUM_BOARDS; b++) begin
      load_en[b] = load_go && (load_board == BRD_W'(b));
      rd_en[b]   = rd_go && (tgt_q == BRD_W'(b));
      shot_en[b] = upd_en && !inv_q && !cur_cell.shot && (tgt_q == BRD_W'(b));
    end
  end

  for (genvar b = 0; b < NUM_BOARDS; b++) begin : g_board
    battleship_board_mem #(
      .ROWS (ROWS),
      .COLS (COLS)
    ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_en),
      .load_en   (load_en[b]),
      .load_row  (load_row),
      .load_col  (load_col),
      .load_ship (MAX_SHIP_W'(load_ship)),
      .load_done (load_done[b]),
      .rd_en     (rd_en[b]),
      .rd_row    (row_q[ROW_W-1:0]),
      .rd_col    (col_q[COL_W-1:0]),
      .rd_cell   (rd_cell[b]),
      .shot_en   (shot_en[b]),
      .disp_row  (disp_row),
      .disp_col  (disp_col),
      .disp_cell (mem_disp[b])
    );
  end

`ifdef SHIP_SUNK_EN
  // Remaining unshot cells per ship; entry s holds ship ID s+1.
  logic [LIFE_W-1:0] ship_cnt [NUM_BOARDS][NUM_SHIPS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BOARDS; b++)
        for (int s = 0; s < NUM_SHIPS; s++) ship_cnt[b][s] <= '0;
    end else if (clear_en) begin
      for (int b = 0; b < NUM_BOARDS; b++)
        for (int s = 0; s < NUM_SHIPS; s++) ship_cnt[b][s] <= '0;
    end else begin
      for (int b = 0; b < NUM_BOARDS; b++)
        for (int s = 0; s < NUM_SHIPS; s++) begin
          if (load_done[b] && (int'(load_ship) == s + 1))
            ship_cnt[b][s] <= ship_cnt[b][s] + LIFE_W'(1);
          else if (hit_now && (tgt_q == BRD_W'(b)) && (int'(cur_cell.ship_id) == s + 1) &&
                   (ship_cnt[b][s] != '0))
            ship_cnt[b][s] <= ship_cnt[b][s] - LIFE_W'(1);
        end
    end
  end

  always_comb begin
    sunk_now = 1'b0;
    for (int b = 0; b < NUM_BOARDS; b++)
      for (int s = 0; s < NUM_SHIPS; s++)
        if (hit_now && (tgt_q == BRD_W'(b)) && (int'(cur_cell.ship_id) == s + 1) &&
            (ship_cnt[b][s] == LIFE_W'(1)))
          sunk_now = 1'b1;
  end
`else
  assign sunk_now = 1'b0;
`endif

  // Response fields update on the UPDATE edge, become visible with resp_valid and hold afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_hit     <= 1'b0;
      resp_repeat  <= 1'b0;
      resp_invalid <= 1'b0;
      resp_ship    <= '0;
      resp_sunk    <= 1'b0;
    end else if (clear_en) begin
      resp_hit     <= 1'b0;
      resp_repeat  <= 1'b0;
      resp_invalid <= 1'b0;
      resp_ship    <= '0;
      resp_sunk    <= 1'b0;
    end else if (upd_en) begin
      resp_hit     <= hit_now;
      resp_repeat  <= !inv_q && cur_cell.shot;
      resp_invalid <= inv_q;
      resp_ship    <= hit_now ? cur_cell.ship_id[SHIP_W-1:0] : '0;
      resp_sunk    <= sunk_now;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BOARDS; b++) life_q[b] <= '0;
      loaded_q <= '0;
    end else if (clear_en) begin
      for (int b = 0; b < NUM_BOARDS; b++) life_q[b] <= '0;
      loaded_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BOARDS; b++) begin
        if (load_done[b]) begin
          life_q[b]   <= life_q[b] + LIFE_W'(1);
          loaded_q[b] <= 1'b1;
        end else if (hit_now && (tgt_q == BRD_W'(b)) && (life_q[b] != '0)) begin
          life_q[b] <= life_q[b] - LIFE_W'(1);
        end
      end
    end
  end

  always_comb begin
    life      = '0;
    game_over = '0;
    for (int b = 0; b < NUM_BOARDS; b++) begin
      life[b*LIFE_W +: LIFE_W] = life_q[b];
      game_over[b]             = loaded_q[b] && (life_q[b] == '0);
    end
  end

  always_comb begin
    disp_cell = WATER;
    for (int b = 0; b < NUM_BOARDS; b++)
      if (disp_board == BRD_W'(b)) disp_cell = cell_code(mem_disp[b]);
  end

endmodule
